// File: rtl/noc_pkg.sv
// Shared types for the NoC router output port.
// Flit type encoding, field geometry and port FSM states.
package noc_pkg;

  localparam int FLIT_W_DEF = 34;
  localparam int TYPE_W     = 2;

  typedef enum logic [1:0] {
    HEAD      = 2'b00,
    BODY      = 2'b01,
    TAIL      = 2'b10,
    HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Type field sits in the top TYPE_W bits of every flit.
  function automatic flit_type_e type_of(input logic [TYPE_W-1:0] t);
    return flit_type_e'(t);
  endfunction

endpackage

// File: rtl/noc_output_port_reg.sv
// Single-entry valid/ready output register for the router port.
// A load and a downstream accept on the same edge replace the flit.
module noc_out_reg #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         out_ready,
  output logic         can_load,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    can_load = !valid_q | out_ready;
    valid_d  = load | (valid_q & !out_ready);
    data_d   = load ? din : data_q;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/noc_output_port.sv
// Output port of a 2-input wormhole router: arbiter glue,
// packet lock, protocol error flag and completed-packet count.
module noc_output_port
  import noc_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                arst,
  input  logic [1:0]          in_valid,
  input  logic [2*FLIT_W-1:0] in_data,
  output logic [1:0]          in_ready,
  output logic [1:0]          req_o,
  input  logic [1:0]          grant_i,
  output logic                update_o,
  output logic                out_valid,
  output logic [FLIT_W-1:0]   out_data,
  input  logic                out_ready,
  output logic                err_o,
  output logic [CNT_W-1:0]    pkt_cnt_o
);

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               err_q, err_d;
  logic               upd_q, upd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               can_load;
  logic               load;
  logic               gnt_1hot;
  logic               sel;
  logic               xfer;
  logic [FLIT_W-1:0]  flit;
  flit_type_e         ftype;

  always_comb begin
    gnt_1hot = (grant_i == 2'b01) | (grant_i == 2'b10);
    sel      = (state_q == LOCKED) ? owner_q : grant_i[1];
    flit     = sel ? in_data[2*FLIT_W-1:FLIT_W]
                   : in_data[FLIT_W-1:0];
    ftype    = type_of(flit[FLIT_W-1 -: TYPE_W]);

    in_ready = 2'b00;
    req_o    = 2'b00;
    if (!arst) begin
      if (state_q == IDLE) begin
        req_o    = in_valid;
        in_ready = grant_i & in_valid
                 & {2{can_load & gnt_1hot}};
      end else begin
        in_ready[owner_q] = in_valid[owner_q] & can_load;
      end
    end
    xfer = |in_ready;

    state_d = state_q;
    owner_d = owner_q;
    err_d   = err_q;
    upd_d   = 1'b0;
    load    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_i == 2'b11) err_d = 1'b1;
        if (xfer) begin
          unique case (ftype)
            HEAD: begin
              load    = 1'b1;
              state_d = LOCKED;
              owner_d = sel;
            end
            HEAD_TAIL: begin
              load  = 1'b1;
              upd_d = 1'b1;
            end
            BODY, TAIL: err_d = 1'b1;
          endcase
        end
      end
      LOCKED: begin
        if (xfer) begin
          load = 1'b1;
          unique case (ftype)
            TAIL: begin
              state_d = IDLE;
              upd_d   = 1'b1;
            end
            HEAD, HEAD_TAIL: err_d = 1'b1;
            BODY: ;
          endcase
        end
      end
    endcase

    cnt_d = upd_d ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      err_q   <= 1'b0;
      upd_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      err_q   <= err_d;
      upd_q   <= upd_d;
      cnt_q   <= cnt_d;
    end
  end

  noc_out_reg #(.W(FLIT_W)) u_out_reg (
    .clk       (clk),
    .arst      (arst),
    .load      (load),
    .din       (flit),
    .out_ready (out_ready),
    .can_load  (can_load),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  assign update_o  = upd_q;
  assign err_o     = err_q;
  assign pkt_cnt_o = cnt_q;

endmodule

// File: tb/tb_noc_output_port.sv
// Directed bench for noc_output_port (counter narrowed to
// 4 bits so the wrap is reachable in a few cycles).
module tb_noc_output_port;

  localparam int FW = 34;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          arst;
  logic [1:0]    in_valid;
  logic [FW-1:0] d0, d1;
  logic [1:0]    in_ready;
  logic [1:0]    req_o;
  logic [1:0]    grant_i;
  logic          update_o;
  logic          out_valid;
  logic [FW-1:0] out_data;
  logic          out_ready;
  logic          err_o;
  logic [CW-1:0] pkt_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  noc_output_port #(.FLIT_W(FW), .CNT_W(CW)) dut (
    .clk       (clk),
    .arst      (arst),
    .in_valid  (in_valid),
    .in_data   ({d1, d0}),
    .in_ready  (in_ready),
    .req_o     (req_o),
    .grant_i   (grant_i),
    .update_o  (update_o),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .err_o     (err_o),
    .pkt_cnt_o (pkt_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mk(
    input logic [1:0] t, input logic [31:0] p);
    return {t, p};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    arst = 1'b1; in_valid = 2'b11; grant_i = 2'b11;
    d0 = '0; d1 = '0; out_ready = 1'b1;

    @(negedge clk); #1;
    chk("rst_req", req_o, 2'b00);
    chk("rst_rdy", in_ready, 2'b00);
    chk("rst_ov", out_valid, 0);
    chk("rst_cnt", pkt_cnt_o, 0);
    chk("rst_err", err_o, 0);

    @(negedge clk);
    arst = 1'b0; in_valid = 2'b00; grant_i = 2'b00;

    // single-flit packet
    @(negedge clk);
    in_valid = 2'b01; grant_i = 2'b01; d0 = mk(2'b11, 32'h1234); #1;
    chk("ht_rdy", in_ready, 2'b01);
    chk("ht_req", req_o, 2'b01);
    chk("ht_ov0", out_valid, 0);
    @(negedge clk);
    in_valid = 2'b00; grant_i = 2'b00; #1;
    chk("ht_ov", out_valid, 1);
    chk("ht_dat", out_data, mk(2'b11, 32'h1234));
    chk("ht_upd", update_o, 1);
    chk("ht_cnt", pkt_cnt_o, 1);
    chk("ht_rdy0", in_ready, 2'b00);
    @(negedge clk); #1;
    chk("ht_upd0", update_o, 0);
    chk("ht_ovd", out_valid, 0);

    // wormhole lock on input 1, input 0 waiting
    @(negedge clk);
    in_valid = 2'b11; grant_i = 2'b10;
    d0 = mk(2'b00, 32'hA0); d1 = mk(2'b00, 32'hB0); #1;
    chk("wh_req", req_o, 2'b11);
    chk("wh_rdy", in_ready, 2'b10);
    @(negedge clk);
    grant_i = 2'b01; d1 = mk(2'b01, 32'hB1); #1;
    chk("wh_req_l", req_o, 2'b00);
    chk("wh_rdy1", in_ready, 2'b10);
    chk("wh_d0", out_data, mk(2'b00, 32'hB0));
    @(negedge clk);
    d1 = mk(2'b01, 32'hB2); #1;
    chk("wh_rdy2", in_ready, 2'b10);
    chk("wh_d1", out_data, mk(2'b01, 32'hB1));
    @(negedge clk);
    d1 = mk(2'b10, 32'hB3); #1;
    chk("wh_rdy3", in_ready, 2'b10);
    chk("wh_d2", out_data, mk(2'b01, 32'hB2));
    chk("wh_upd0", update_o, 0);
    @(negedge clk);
    in_valid = 2'b00; grant_i = 2'b00; #1;
    chk("wh_d3", out_data, mk(2'b10, 32'hB3));
    chk("wh_upd", update_o, 1);
    chk("wh_cnt", pkt_cnt_o, 2);
    @(negedge clk); #1;
    chk("wh_upd1", update_o, 0);
    chk("wh_err", err_o, 0);

    // backpressure mid-packet
    @(negedge clk);
    in_valid = 2'b01; grant_i = 2'b01; d0 = mk(2'b00, 32'hC0); #1;
    chk("bp_rdy0", in_ready, 2'b01);
    @(negedge clk);
    grant_i = 2'b00; d0 = mk(2'b01, 32'hC1); #1;
    chk("bp_rdy1", in_ready, 2'b01);
    chk("bp_d0", out_data, mk(2'b00, 32'hC0));
    @(negedge clk);
    d0 = mk(2'b01, 32'hC2); out_ready = 1'b0; #1;
    chk("bp_stall_rdy", in_ready, 2'b00);
    chk("bp_stall_d", out_data, mk(2'b01, 32'hC1));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("bp_hold_rdy", in_ready, 2'b00);
      chk("bp_hold_d", out_data, mk(2'b01, 32'hC1));
      chk("bp_hold_v", out_valid, 1);
    end
    @(negedge clk);
    out_ready = 1'b1; #1;
    chk("bp_res_rdy", in_ready, 2'b01);
    chk("bp_res_d", out_data, mk(2'b01, 32'hC1));
    @(negedge clk);
    d0 = mk(2'b10, 32'hC3); #1;
    chk("bp_d2", out_data, mk(2'b01, 32'hC2));
    chk("bp_rdy3", in_ready, 2'b01);
    @(negedge clk);
    in_valid = 2'b00; #1;
    chk("bp_d3", out_data, mk(2'b10, 32'hC3));
    chk("bp_upd", update_o, 1);
    chk("bp_cnt", pkt_cnt_o, 3);
    @(negedge clk); #1;
    chk("bp_ovd", out_valid, 0);

    // BODY in IDLE is dropped and flagged
    @(negedge clk);
    in_valid = 2'b01; grant_i = 2'b01; d0 = mk(2'b01, 32'hD1); #1;
    chk("e1_rdy", in_ready, 2'b01);
    @(negedge clk);
    in_valid = 2'b00; grant_i = 2'b00; #1;
    chk("e1_ov", out_valid, 0);
    chk("e1_err", err_o, 1);
    chk("e1_cnt", pkt_cnt_o, 3);
    @(negedge clk);
    arst = 1'b1; #1;
    chk("e1_clr", err_o, 0);
    @(negedge clk);
    arst = 1'b0;

    // two grants at once
    @(negedge clk);
    in_valid = 2'b11; grant_i = 2'b11;
    d0 = mk(2'b11, 32'hE0); d1 = mk(2'b11, 32'hE1); #1;
    chk("e2_rdy", in_ready, 2'b00);
    @(negedge clk);
    in_valid = 2'b00; grant_i = 2'b00; #1;
    chk("e2_err", err_o, 1);
    chk("e2_ov", out_valid, 0);
    chk("e2_cnt", pkt_cnt_o, 0);

    // reset mid-packet
    @(negedge clk);
    in_valid = 2'b01; grant_i = 2'b01; d0 = mk(2'b00, 32'hF0); #1;
    chk("mr_rdy0", in_ready, 2'b01);
    @(negedge clk);
    grant_i = 2'b00; d0 = mk(2'b01, 32'hF1); #1;
    chk("mr_rdy1", in_ready, 2'b01);
    chk("mr_d0", out_data, mk(2'b00, 32'hF0));
    @(negedge clk);
    arst = 1'b1; d0 = mk(2'b01, 32'hF2); #1;
    chk("mr_ov", out_valid, 0);
    chk("mr_od", out_data, 0);
    chk("mr_err", err_o, 0);
    chk("mr_cnt", pkt_cnt_o, 0);
    chk("mr_rdy", in_ready, 2'b00);
    chk("mr_req", req_o, 2'b00);
    chk("mr_upd", update_o, 0);
    @(negedge clk);
    arst = 1'b0; grant_i = 2'b01; d0 = mk(2'b11, 32'h55); #1;
    chk("mr_idle_req", req_o, 2'b01);
    chk("mr_idle_rdy", in_ready, 2'b01);
    @(negedge clk);
    in_valid = 2'b00; grant_i = 2'b00; #1;
    chk("mr_ht_d", out_data, mk(2'b11, 32'h55));
    chk("mr_ht_upd", update_o, 1);
    chk("mr_ht_cnt", pkt_cnt_o, 1);

    // back-to-back single-flit packets, counter wrap
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      in_valid = 2'b01; grant_i = 2'b01;
      d0 = mk(2'b11, 32'(k)); #1;
      chk("bb_rdy", in_ready, 2'b01);
      if (k > 0) begin
        chk("bb_upd", update_o, 1);
        chk("bb_d", out_data, mk(2'b11, 32'(k - 1)));
      end
    end
    @(negedge clk);
    in_valid = 2'b00; grant_i = 2'b00; #1;
    chk("bb_wrap", pkt_cnt_o, 0);
    chk("bb_upd_last", update_o, 1);
    chk("bb_d_last", out_data, mk(2'b11, 32'd14));
    @(negedge clk); #1;
    chk("bb_upd_end", update_o, 0);
    chk("bb_err", err_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
